// File: rtl/result_capture_module.sv
// Score sink for the inference datapath. It buffers one score vector, tracks
// a running signed argmax and counts cycles from arm to completion. Scores,
// the winning class and status are exposed to the register wrapper.
module result_capture_module #(
    parameter int N_OUTPUTS = 10,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 4,
    parameter int CNT_W     = 32
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_areset,
    input  logic              start,
    input  logic [DATA_W-1:0] y_tdata,
    input  logic              y_tvalid,
    input  logic              y_tlast,
    output logic              y_tready,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_score,
    output logic              err_len,
    output logic [CNT_W-1:0]  cycle_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_OUTPUTS - 1);
    localparam logic [IDX_W:0]   N_BOUND   = (IDX_W + 1)'(N_OUTPUTS);

    state_t            state;
    state_t            next_state;
    logic              start_q;
    logic              start_edge;
    logic              beat;
    logic              is_last_slot;
    logic              is_final;
    logic              rd_in_range;
    logic [IDX_W-1:0]  beat_idx;
    logic [DATA_W-1:0] max_score;
    logic [IDX_W-1:0]  max_idx;
    logic [DATA_W-1:0] new_score;
    logic [IDX_W-1:0]  new_idx;
    logic [DATA_W-1:0] score_buf [N_OUTPUTS];

    assign start_edge   = start & ~start_q;
    assign beat         = y_tvalid & y_tready;
    assign is_last_slot = (beat_idx == LAST_IDX);
    assign is_final     = is_last_slot | y_tlast;
    assign rd_in_range  = ({1'b0, rd_addr} < N_BOUND);

    // State register
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and state-derived handshake/status outputs
    always_comb begin
        next_state = state;
        y_tready   = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                y_tready = 1'b1;
                if (beat && is_final) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start_edge) begin
                    next_state = ST_CAPTURE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Running argmax including the current beat; strict compare keeps the lower index on ties
    always_comb begin
        new_score = max_score;
        new_idx   = max_idx;
        if (beat_idx == '0 || $signed(y_tdata) > $signed(max_score)) begin
            new_score = y_tdata;
            new_idx   = beat_idx;
        end
    end

    // Capture datapath, result registers, cycle counter and read port
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            start_q     <= 1'b0;
            beat_idx    <= '0;
            max_score   <= '0;
            max_idx     <= '0;
            class_idx   <= '0;
            class_score <= '0;
            err_len     <= 1'b0;
            cycle_cnt   <= '0;
            rd_data     <= '0;
            for (int unsigned i = 0; i < N_OUTPUTS; i++) begin
                score_buf[i] <= '0;
            end
        end else begin
            start_q <= start;
            rd_data <= rd_in_range ? score_buf[rd_addr] : '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_edge) begin
                        beat_idx  <= '0;
                        cycle_cnt <= '0;
                        err_len   <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (cycle_cnt != '1) begin
                        cycle_cnt <= cycle_cnt + 1'b1;
                    end
                    if (beat) begin
                        score_buf[beat_idx] <= y_tdata;
                        beat_idx            <= beat_idx + 1'b1;
                        max_score           <= new_score;
                        max_idx             <= new_idx;
                        if (is_final) begin
                            class_score <= new_score;
                            class_idx   <= new_idx;
                            // Early tlast, or a full vector without tlast on its last beat
                            err_len     <= y_tlast ^ is_last_slot;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_result_capture_module.sv
// Self-checking bench for result_capture_module: directed vectors plus
// randomized vectors scored against a behavioural argmax/buffer model.
// A second instance with a narrow counter exercises counter saturation.
module tb_result_capture_module;

    localparam int N  = 10;
    localparam int DW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] y_tdata;
    logic          y_tvalid;
    logic          y_tlast;
    logic [IW-1:0] rd_addr;

    logic          y_tready, done, err_len;
    logic [DW-1:0] rd_data, class_score;
    logic [IW-1:0] class_idx;
    logic [31:0]   cycle_cnt;

    logic          y_tready_s, done_s, err_len_s;
    logic [DW-1:0] rd_data_s, class_score_s;
    logic [IW-1:0] class_idx_s;
    logic [3:0]    cycle_cnt_s;

    always #5 clk = ~clk;

    result_capture_module #(.N_OUTPUTS(N), .DATA_W(DW), .IDX_W(IW), .CNT_W(32)) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst), .start(start),
        .y_tdata(y_tdata), .y_tvalid(y_tvalid), .y_tlast(y_tlast), .y_tready(y_tready),
        .rd_addr(rd_addr), .rd_data(rd_data), .done(done), .class_idx(class_idx),
        .class_score(class_score), .err_len(err_len), .cycle_cnt(cycle_cnt)
    );

    result_capture_module #(.N_OUTPUTS(N), .DATA_W(DW), .IDX_W(IW), .CNT_W(4)) dut_s (
        .s_axi_aclk(clk), .s_axi_areset(rst), .start(start),
        .y_tdata(y_tdata), .y_tvalid(y_tvalid), .y_tlast(y_tlast), .y_tready(y_tready_s),
        .rd_addr(rd_addr), .rd_data(rd_data_s), .done(done_s), .class_idx(class_idx_s),
        .class_score(class_score_s), .err_len(err_len_s), .cycle_cnt(cycle_cnt_s)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Vector under test and reference score buffer
    logic [DW-1:0] vd [N];
    logic          vl [N];
    int            vg [N];
    logic [DW-1:0] model_buf [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_tready"}, {63'd0, y_tready}, 64'd0);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_err"}, {63'd0, err_len}, 64'd0);
        check({tag, "_idx"}, {60'd0, class_idx}, 64'd0);
        check({tag, "_score"}, {32'd0, class_score}, 64'd0);
        check({tag, "_cnt"}, {32'd0, cycle_cnt}, 64'd0);
        check({tag, "_rd"}, {32'd0, rd_data}, 64'd0);
        check({tag, "_s_done"}, {63'd0, done_s}, 64'd0);
        check({tag, "_s_cnt"}, {60'd0, cycle_cnt_s}, 64'd0);
    endtask

    task automatic arm;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("arm_tready", {63'd0, y_tready}, 64'd1);
        check("arm_done", {63'd0, done}, 64'd0);
        check("arm_cnt", {32'd0, cycle_cnt}, 64'd0);
        check("arm_err", {63'd0, err_len}, 64'd0);
    endtask

    task automatic set_vec(input logic [DW-1:0] fill, input int last_at, input int gap);
        for (int i = 0; i < N; i++) begin
            vd[i] = fill;
            vl[i] = (i == last_at);
            vg[i] = (i == 0) ? 0 : gap;
        end
    endtask

    task automatic set_first_vec(input int gap);
        int vals [N] = '{5, -3, 9, 2, 9, 0, 1, -7, 4, 8};
        set_vec('0, 9, gap);
        for (int i = 0; i < N; i++) vd[i] = vals[i];
    endtask

    task automatic run_capture(input int restart_at, input int abort_at);
        int            n;
        logic          exp_err;
        int            exp_idx;
        logic [DW-1:0] exp_score;
        int            exp_cnt;
        int            cyc;
        // Reference: beats accepted up to first tlast or the Nth beat
        n = N;
        for (int i = 0; i < N; i++) begin
            if (vl[i]) begin
                n = i + 1;
                break;
            end
        end
        exp_err   = !(vl[n-1] && n == N);
        exp_idx   = 0;
        exp_score = vd[0];
        exp_cnt   = 0;
        for (int i = 0; i < n; i++) begin
            exp_cnt += 1 + vg[i];
            if ($signed(vd[i]) > $signed(exp_score)) begin
                exp_score = vd[i];
                exp_idx   = i;
            end
        end

        arm();
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) break;
            for (int g = 0; g < vg[i]; g++) begin
                y_tvalid = 1'b0;
                start    = (cyc == restart_at);
                tick();
                cyc++;
            end
            y_tvalid = 1'b1;
            y_tdata  = vd[i];
            y_tlast  = vl[i];
            start    = (cyc == restart_at);
            check("busy_tready_done", {62'd0, y_tready, done}, 64'd2);
            tick();
            cyc++;
            model_buf[i] = vd[i];
        end
        y_tvalid = 1'b0;
        y_tlast  = 1'b0;
        start    = 1'b0;

        if (abort_at >= 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            for (int i = 0; i < N; i++) model_buf[i] = '0;
            check_zero("abort");
            return;
        end

        check("done", {63'd0, done}, 64'd1);
        check("done_tready", {63'd0, y_tready}, 64'd0);
        check("class_idx", {60'd0, class_idx}, 64'(exp_idx));
        check("class_score", {32'd0, class_score}, {32'd0, exp_score});
        check("err_len", {63'd0, err_len}, {63'd0, exp_err});
        check("cycle_cnt", {32'd0, cycle_cnt}, 64'(exp_cnt));
        check("s_done", {63'd0, done_s}, 64'd1);
        check("s_tready", {63'd0, y_tready_s}, 64'd0);
        check("s_class_idx", {60'd0, class_idx_s}, 64'(exp_idx));
        check("s_class_score", {32'd0, class_score_s}, {32'd0, exp_score});
        check("s_err_len", {63'd0, err_len_s}, {63'd0, exp_err});
        check("s_cycle_cnt_sat", {60'd0, cycle_cnt_s}, 64'((exp_cnt > 15) ? 15 : exp_cnt));
        repeat (3) tick();
        check("hold_done", {63'd0, done}, 64'd1);
        check("hold_cnt", {32'd0, cycle_cnt}, 64'(exp_cnt));
        check("hold_score", {32'd0, class_score}, {32'd0, exp_score});
    endtask

    task automatic readback(input int last_addr);
        logic [DW-1:0] prev;
        logic [DW-1:0] exp;
        prev = '0;
        for (int a = 0; a <= last_addr; a++) begin
            exp     = (a < N) ? model_buf[a] : '0;
            rd_addr = IW'(a);
            #1;
            if (a > 0) check("rd_latency", {32'd0, rd_data}, {32'd0, prev});
            tick();
            check("rd_data", {32'd0, rd_data}, {32'd0, exp});
            check("s_rd_data", {32'd0, rd_data_s}, {32'd0, exp});
            prev = exp;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        y_tvalid = 1'b0;
        y_tlast  = 1'b0;
        y_tdata  = '0;
        rd_addr  = '0;
        for (int i = 0; i < N; i++) model_buf[i] = '0;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check_zero("idle");

        // Reference vector, back-to-back
        set_first_vec(0);
        run_capture(-1, -1);
        readback(15);

        // Signed compare: most-negative everywhere except -1 at beat 7
        set_vec(32'h8000_0000, 9, 0);
        vd[7] = 32'hFFFF_FFFF;
        run_capture(-1, -1);

        // All equal: lowest index wins
        set_vec(32'h8000_0000, 9, 0);
        run_capture(-1, -1);

        // Reference vector with valid toggling
        set_first_vec(1);
        run_capture(-1, -1);
        readback(9);

        // Early tlast on beat 4; beats 5..9 keep previous contents
        set_vec('0, 4, 0);
        for (int i = 0; i < N; i++) vd[i] = 32'(100 + i);
        run_capture(-1, -1);
        readback(9);

        // No tlast at all
        set_vec(32'd3, -1, 0);
        vd[6] = 32'd4;
        run_capture(-1, -1);

        // Reset after 6 beats, then a clean capture
        set_first_vec(0);
        run_capture(-1, 6);
        readback(9);
        set_first_vec(0);
        vd[9] = 32'd50;
        run_capture(-1, -1);
        readback(9);

        // Start edge inside capture is ignored
        set_first_vec(0);
        vg[2] = 2;
        run_capture(3, -1);

        // Randomized vectors
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t % 2 == 0) vd[i] = 32'(int'($urandom_range(0, 7)) - 4);
                else            vd[i] = $urandom;
                vl[i] = ($urandom_range(0, 11) == 0);
                vg[i] = int'($urandom_range(0, 2));
            end
            if (t % 5 == 4) vl[N-1] = 1'b1;
            run_capture((t % 3 == 0) ? 1 : -1, -1);
            readback(11);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
